// File: rtl/square_reconstruct_iterative.sv
// square_reconstruct_iterative
//
// Iterative unsigned squarer that rebuilds a radicand from a square-root
// result pair: radicand = root^2 + remainder. The root is consumed one bit
// per cycle, MSB first, with a shift-add accumulator. A single add cycle then
// folds in the remainder. The unit also flags pairs that a square-root unit
// could never have produced (remainder > 2*root).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset (overrides clk_en_i)
//   clk_en_i       clock enable; when low every register holds
//   valid_entry_i  input pair valid (sampled only in IDLE)
//   root_i         root operand, DATA_WIDTH/2 bits
//   remainder_i    remainder operand, DATA_WIDTH/2+1 bits
//   ready_o        high while IDLE
//   radicand_o     low DATA_WIDTH bits of root^2 + remainder (registered)
//   overflow_o     root^2 + remainder >= 2^DATA_WIDTH (registered)
//   invalid_o      remainder > 2*root, updated at accept (registered)
//   data_valid_o   result strobe, high in DONE
//
// DATA_WIDTH must be even and >= 4.

module square_reconstruct_iterative #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic                    valid_entry_i,
  input  logic [DATA_WIDTH/2-1:0] root_i,
  input  logic [DATA_WIDTH/2:0]   remainder_i,
  output logic                    ready_o,
  output logic [DATA_WIDTH-1:0]   radicand_o,
  output logic                    overflow_o,
  output logic                    invalid_o,
  output logic                    data_valid_o
);

  localparam int ROOT_W     = DATA_WIDTH / 2;
  localparam int ITERATIONS = ROOT_W;
  localparam int CNT_W      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ADD    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_reg,     state_next;
  logic [CNT_W-1:0]       counter_reg,   counter_next;
  logic [ROOT_W-1:0]      root_reg,      root_next;
  logic [ROOT_W:0]        remainder_reg, remainder_next;
  logic [DATA_WIDTH-1:0]  acc_reg,       acc_next;
  logic [DATA_WIDTH-1:0]  radicand_reg,  radicand_next;
  logic                   overflow_reg,  overflow_next;
  logic                   invalid_reg,   invalid_next;

  // Partial product for the current root bit: root gated by root[counter].
  logic                   root_bit;
  logic [ROOT_W-1:0]      partial;
  logic [DATA_WIDTH-1:0]  addend;
  logic [DATA_WIDTH:0]    sum;

  assign root_bit = root_reg[counter_reg];

  genvar gi;
  generate
    for (gi = 0; gi < ROOT_W; gi++) begin : g_partial
      assign partial[gi] = root_reg[gi] & root_bit;
    end
  endgenerate

  assign addend = {{(DATA_WIDTH - ROOT_W){1'b0}}, partial};

  // One extra bit so the remainder add can report overflow.
  assign sum = {1'b0, acc_reg} + {{(DATA_WIDTH - ROOT_W){1'b0}}, remainder_reg};

  // State and datapath registers. clk_en_i low freezes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      counter_reg   <= CNT_LAST;
      root_reg      <= '0;
      remainder_reg <= '0;
      acc_reg       <= '0;
      radicand_reg  <= '0;
      overflow_reg  <= 1'b0;
      invalid_reg   <= 1'b0;
    end else if (clk_en_i) begin
      state_reg     <= state_next;
      counter_reg   <= counter_next;
      root_reg      <= root_next;
      remainder_reg <= remainder_next;
      acc_reg       <= acc_next;
      radicand_reg  <= radicand_next;
      overflow_reg  <= overflow_next;
      invalid_reg   <= invalid_next;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_next     = state_reg;
    counter_next   = counter_reg;
    root_next      = root_reg;
    remainder_next = remainder_reg;
    acc_next       = acc_reg;
    radicand_next  = radicand_reg;
    overflow_next  = overflow_reg;
    invalid_next   = invalid_reg;
    ready_o        = 1'b0;
    data_valid_o   = 1'b0;

    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_entry_i) begin
          state_next     = SQUARE;
          root_next      = root_i;
          remainder_next = remainder_i;
          acc_next       = '0;
          counter_next   = CNT_LAST;
          // A canonical pair satisfies remainder <= 2*root.
          invalid_next   = (remainder_i > {root_i, 1'b0});
        end
      end

      SQUARE: begin
        // MSB-first shift-add; root^2 always fits in DATA_WIDTH bits.
        acc_next = {acc_reg[DATA_WIDTH-2:0], 1'b0} + addend;
        if (counter_reg == '0) begin
          counter_next = CNT_LAST;
          state_next   = ADD;
        end else begin
          counter_next = counter_reg - 1'b1;
        end
      end

      ADD: begin
        radicand_next = sum[DATA_WIDTH-1:0];
        overflow_next = sum[DATA_WIDTH];
        state_next    = DONE;
      end

      DONE: begin
        data_valid_o = 1'b1;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign radicand_o = radicand_reg;
  assign overflow_o = overflow_reg;
  assign invalid_o  = invalid_reg;

endmodule

// File: doc/square_reconstruct_iterative.md
# square_reconstruct_iterative

Iterative unsigned squarer that rebuilds a radicand from a (root, remainder) pair: radicand = root² + remainder. It is the inverse of the team's iterative non-restoring square-root unit. It sits alongside that unit in the integer arithmetic library and is used both as a datapath operator and as an in-system checker for square-root results. It takes one bit of the root per cycle, uses a shift-add accumulator, runs a single add cycle for the remainder, and flags non-canonical input pairs.

## Interface
- DATA_WIDTH, 32: radicand width; must be even and ≥ 4. ROOT_W = DATA_WIDTH/2 and ITERATIONS = ROOT_W are derived locally.
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  reset. One clock; reset is synchronous and active-high.
- clk_en_i  input  1  clock enable; when low, every register holds.
- valid_entry_i  input  1  input pair valid.
- root_i  input  ROOT_W  root operand.
- remainder_i  input  ROOT_W+1  remainder operand.
- ready_o  output  1  unit can accept a pair; high only in IDLE.
- radicand_o  output  DATA_WIDTH  low DATA_WIDTH bits of root² + remainder.
- overflow_o  output  1  root² + remainder ≥ 2^DATA_WIDTH.
- invalid_o  output  1  remainder_i > 2·root_i, i.e. not a canonical square-root pair.
- data_valid_o  output  1  one-cycle result strobe.

## Operation
- The FSM has four states: IDLE, SQUARE, ADD, DONE. Reset state is IDLE.
- IDLE
  - ready_o = 1.
  - A pair is accepted when valid_entry_i & clk_en_i.
  - On accept: latch root_i and remainder_i; clear the accumulator (DATA_WIDTH bits); set counter = ITERATIONS-1; register invalid = (remainder_i > {root_i,1'b0}).
  - Next state is SQUARE.
- SQUARE
  - acc ← (acc << 1) + (root[counter] ? root : 0), truncated to DATA_WIDTH. It never truncates, because root² < 2^DATA_WIDTH.
  - The counter decrements each cycle.
  - When counter = 0, next state is ADD. The counter wraps to ITERATIONS-1 and is unused afterwards.
- ADD
  - sum = acc + remainder, computed at DATA_WIDTH+1 bits.
  - radicand register ← sum[DATA_WIDTH-1:0]; overflow register ← sum[DATA_WIDTH].
  - Next state is DONE.
- DONE
  - data_valid_o = 1.
  - Next state is IDLE.
- Output behaviour:
  - radicand_o, overflow_o and invalid_o are registered.
  - They hold the last result until the ADD cycle of the next operation updates them.
  - invalid_o updates at accept.
- valid_entry_i is ignored outside IDLE. Inputs are sampled only at accept; later changes to root_i or remainder_i have no effect.
- Reset mid-operation aborts the operation: the state returns to IDLE and no data_valid_o is produced.
- Any canonical pair (remainder ≤ 2·root) never sets overflow_o.

## Timing
- Reset values: ready_o=1 (state is IDLE), radicand_o=0, overflow_o=0, invalid_o=0, data_valid_o=0. All internal registers are 0; the counter resets to ITERATIONS-1.
- Reset is sampled at the rising edge and overrides clk_en_i.
- Latency, with accept at cycle T:
  - SQUARE occupies T+1 … T+ITERATIONS.
  - ADD occupies T+ITERATIONS+1.
  - data_valid_o is high in cycle T+ITERATIONS+2 (T+18 for DATA_WIDTH=32), and only for that one cycle.
- Throughput: ready_o rises again at T+ITERATIONS+3, so the accept-to-accept minimum is ITERATIONS+3 cycles.
- clk_en_i low freezes the state, the counter and all registers. data_valid_o stays high while the unit is frozen in DONE, and completion is delayed by the number of stalled cycles.
- If valid_entry_i is high during DONE, it is not accepted until IDLE.

## Test plan
- Reset, then root=5, remainder=3, valid at T → radicand_o=28, overflow_o=0, invalid_o=0, data_valid_o high exactly at T+18, ready_o low for T+1…T+18.
- Maximum canonical pair: root=0xFFFF, remainder=0x1FFFE → radicand_o=0xFFFFFFFF, overflow_o=0, invalid_o=0.
- Overflow: root=0xFFFF, remainder=0x1FFFF → radicand_o=0, overflow_o=1, invalid_o=1. Also root=3, remainder=7 → radicand_o=16, invalid_o=1, overflow_o=0.
- Zero and back-to-back operation:
  - root=0, remainder=0 → radicand_o=0.
  - valid_entry_i held high with root=9, remainder=0 → the next accept lands at the first IDLE cycle, radicand_o=81, and there are ITERATIONS+3 cycles between strobes.
  - Changing root_i while the unit is busy does not alter the result.
- Stall: clk_en_i low for 5 cycles during SQUARE → data_valid_o at T+23 and the result is unchanged. A stall held during DONE keeps data_valid_o high for the whole stall.
- Reset asserted at T+6 mid-SQUARE → IDLE next cycle, ready_o=1, all outputs 0, and no data_valid_o pulse follows.
